instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch and issue stage for the 16-bit GPR processor. Holds a small loadable program memory, walks it with a program counter, and presents each 32-bit instruction word to the execute stage over a valid/ready handshake. It is the producer side of the instruction-register interface the execute stage consumes. It filters illegal opcodes and stops on a HALT word or at the end of memory.

## Interface
- IMEM_DEPTH, 16, number of 32-bit program words; power of two, ≥2
- ADDR_W, $clog2(IMEM_DEPTH), PC / load address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- load_en  in  1  write load_data to load_addr (honoured only in IDLE/DONE)
- load_addr  in  ADDR_W  program-memory write address
- load_data  in  32  program-memory write data
- start  in  1  begin execution from PC 0 (honoured only in IDLE/DONE)
- abort  in  1  synchronous return to IDLE from any state
- ir_out  out  32  instruction word to execute stage
- ir_valid  out  1  ir_out holds an instruction
- ir_ready  in  1  execute stage accepts ir_out
- pc  out  ADDR_W  address of the word currently fetched/issued
- busy  out  1  state is FETCH or ISSUE
- done  out  1  state is DONE
- illegal_cnt  out  8  count of skipped illegal words, saturating at 255

## Operation
- Opcode = bits [31:27]. Legal: MOVSGPR 0, MOV 1, ADD 2, SUB 3, MUL 4. HALT = 31. Opcodes 5–30 are illegal.
- States: IDLE, FETCH, CHECK, ISSUE, DONE.
  - IDLE: start → FETCH with pc=0 and illegal_cnt=0.
  - FETCH: presents pc to memory → CHECK.
  - CHECK: memory data is valid.
    - HALT → DONE; word not issued.
    - Illegal → illegal_cnt+1 (saturating). Then pc+1 and FETCH if pc<IMEM_DEPTH-1, else DONE.
    - Legal → ISSUE; ir_out is loaded with the word.
  - ISSUE: ir_valid=1. ir_valid and ir_out stay stable until ir_ready=1 is sampled. On that acceptance, pc+1 and FETCH if pc<IMEM_DEPTH-1, else DONE.
  - DONE: start → FETCH with pc=0 and illegal_cnt=0.
- End of memory: pc never wraps. After the last word, the FSM enters DONE with pc=IMEM_DEPTH-1. On HALT, pc holds the HALT address.
- load_en in FETCH/CHECK/ISSUE is ignored; memory is unchanged. start in those states is ignored.
- load_en and start in the same IDLE cycle: the write takes effect. If load_addr=0, the first fetch returns the new word.
- abort has priority over start, load, and handshake. Next state is IDLE with ir_valid=0, even mid-ISSUE; this is the only legal withdrawal of valid. pc and illegal_cnt hold their values.
- Memory contents are not reset; the bench loads before start.

## Timing
- Reset values: ir_out=0, ir_valid=0, pc=0, busy=0, done=0, illegal_cnt=0, state IDLE. Reset is asynchronous, mid-operation included; memory is preserved.
- Synchronous-read memory has 1-cycle latency.
- Start at edge N: FETCH at N+1, CHECK at N+2, ISSUE (ir_valid=1) at N+3.
- Legal word, ir_ready held high: one instruction every 3 cycles.
- Illegal word: 2 cycles per skipped word.
- Handshake: transfer occurs on an edge where ir_valid & ir_ready. ir_ready while ir_valid=0 has no effect. ir_valid drops the cycle after transfer.
- done asserts the cycle after the CHECK or ISSUE cycle that terminates execution.

## Structure
- Shared package proc_isa_pkg holds:
  - opcode constants MOVSGPR, MOV, ADD, SUB, MUL, HALT;
  - instruction field bit positions (oper, rdst, rsrc1, mode, rsrc2, imm);
  - function is_legal_op;
  - fetch state enum.
- Sub-module imem_sync: IMEM_DEPTH×32 single-port memory with synchronous write, synchronous read, and no reset.
- The FSM, pc, illegal counter, and output register live in instr_fetch_unit.

## Test plan
- Reset, then load words 0x0880_0005 (MOV imm), 0x1084_0003 (ADD imm), 0xF800_0000 (HALT), then start with ir_ready=1. Required:
  - exactly two transfers, in order;
  - done=1 with pc=2;
  - illegal_cnt=0.
- Same program with ir_ready held low for 5 cycles during the first ISSUE. Required:
  - ir_valid=1 and ir_out=0x0880_0005 stable for all 5 cycles;
  - transfer on the first ready edge.
- Word 0 = 0x2800_0000 (opcode 5), word 1 = legal MOV, word 2 = HALT. Required: one transfer (the MOV) and illegal_cnt=1.
- All 16 words legal MOV with no HALT. Required: 16 transfers, then done=1 with pc=15; no wrap.
- abort in the second ISSUE cycle while ir_ready=0. Required:
  - next cycle ir_valid=0, state IDLE;
  - pc unchanged;
  - a load_en in the same cycle is not written.
- rst_n pulsed low mid-ISSUE. Required:
  - all outputs go to reset values immediately;
  - a following start re-executes the unchanged program from pc 0.

Source files
------------

// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the 16-bit GPR processor.
// Holds the opcode constants, the instruction field positions, the opcode
// legality check and the fetch-stage state encoding.
package proc_isa_pkg;

  // Opcode values, held in bits [31:27] of the instruction word
  localparam logic [4:0] MOVSGPR = 5'd0;
  localparam logic [4:0] MOV     = 5'd1;
  localparam logic [4:0] ADD     = 5'd2;
  localparam logic [4:0] SUB     = 5'd3;
  localparam logic [4:0] MUL     = 5'd4;
  localparam logic [4:0] HALT    = 5'd31;

  // Instruction field bit positions
  localparam int unsigned OPER_MSB  = 31;
  localparam int unsigned OPER_LSB  = 27;
  localparam int unsigned RDST_MSB  = 26;
  localparam int unsigned RDST_LSB  = 22;
  localparam int unsigned RSRC1_MSB = 21;
  localparam int unsigned RSRC1_LSB = 17;
  localparam int unsigned MODE_BIT  = 16;
  localparam int unsigned RSRC2_MSB = 15;
  localparam int unsigned RSRC2_LSB = 11;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;

  // Opcodes 0..4 are executable; HALT is handled separately by the fetch FSM
  function automatic logic is_legal_op(input logic [4:0] op);
    return (op <= MUL);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_DONE
  } fetch_state_t;

endpackage

// File: rtl/imem_sync.sv
// Program memory: IMEM_DEPTH x 32-bit single-port RAM, synchronous write,
// synchronous read (one-cycle latency), no reset of the contents.
// Ports: i_clk clock; i_we write enable; i_addr shared read/write address;
//        i_wdata write data; o_rdata registered read data.
module imem_sync #(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [IMEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and issue stage. Walks the loadable program memory with a
// program counter, skips illegal opcodes, stops on HALT or at the last word,
// and offers each legal word to the execute stage over valid/ready.
// Ports: clk, rst_n (async active-low); load_en/load_addr/load_data program
//        load (IDLE/DONE only); start (IDLE/DONE only); abort (sync, to IDLE);
//        ir_out/ir_valid/ir_ready issue handshake; pc current address;
//        busy (FETCH/ISSUE); done (DONE); illegal_cnt skipped-word count.
module instr_fetch_unit
  import proc_isa_pkg::*;
#(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic              abort,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [7:0]        illegal_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_DEPTH - 1);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_ill_cnt;

  logic              w_load_ok;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_rdata;
  logic [4:0]        w_op;

  // Loads are only accepted while the program is not running; abort wins.
  assign w_load_ok = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_we      = load_en && w_load_ok && !abort;
  // The single port is steered to pc only while fetching, so a load issued
  // together with start lands before the first fetch reads address 0.
  assign w_addr    = (r_state == S_FETCH) ? r_pc : load_addr;
  assign w_op      = w_rdata[OPER_MSB:OPER_LSB];

  imem_sync #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_imem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (load_data),
    .o_rdata (w_rdata)
  );

  // busy/done are registered alongside every state change so they always
  // reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ill_cnt <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ill_cnt <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        S_FETCH: begin
          r_state <= S_CHECK;
          r_busy  <= 1'b0;
        end
        S_CHECK: begin
          if (w_op == HALT) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (!is_legal_op(w_op)) begin
            if (r_ill_cnt != '1) begin
              r_ill_cnt <= r_ill_cnt + 8'd1;
            end
            if (r_pc != LAST_PC) begin
              r_pc    <= r_pc + ADDR_W'(1);
              r_state <= S_FETCH;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_ir    <= w_rdata;
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
            r_busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (ir_ready) begin
            r_valid <= 1'b0;
            if (r_pc != LAST_PC) begin
              r_pc    <= r_pc + ADDR_W'(1);
              r_state <= S_FETCH;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ir_out      = r_ir;
  assign ir_valid    = r_valid;
  assign pc          = r_pc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign illegal_cnt = r_ill_cnt;

endmodule
